// File: rtl/accum_bank_if.sv
// Bundle for the accumulator bank. It carries the stage control, the bias
// preload, the addend input handshake and the result output handshake.
interface accum_bank_if #(
   parameter int NUM_CH   = 4,
   parameter int ADDEND_W = 20,
   parameter int SUM_W    = 24,
   parameter int LEN_W    = 8
);
   logic [LEN_W-1:0]           acc_len;
   logic                       bias_load;
   logic [NUM_CH*SUM_W-1:0]    bias_in;
   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_CH*ADDEND_W-1:0] addend;
   logic                       out_valid;
   logic                       out_ready;
   logic [NUM_CH*SUM_W-1:0]    sum_out;
   logic [NUM_CH-1:0]          overflow;

   modport master (
      output acc_len, bias_load, bias_in, in_valid, addend, out_ready,
      input  in_ready, out_valid, sum_out, overflow
   );

   modport slave (
      input  acc_len, bias_load, bias_in, in_valid, addend, out_ready,
      output in_ready, out_valid, sum_out, overflow
   );
endinterface

// File: rtl/accum_bank.sv
// Multi-lane partial-sum accumulator. Each stage sums a latched number of
// signed addends on top of a per-lane bias. The result is held on a
// valid/ready output until the downstream unit takes it.
//
// state | meaning
// IDLE  | waiting for the first beat of a stage
// ACCUM | stage open, collecting the remaining beats
// HOLD  | stage complete, sum_out/overflow presented on out_valid
module accum_bank #(
   parameter int NUM_CH   = 4,
   parameter int ADDEND_W = 20,
   parameter int SUM_W    = 24,
   parameter int LEN_W    = 8,
   parameter bit SAT_EN   = 1'b1
) (
   input logic        clk,
   input logic        layer_reset,
   accum_bank_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

   state_t                  state;
   state_t                  state_nxt;
   logic [LEN_W-1:0]        cnt;
   logic [LEN_W-1:0]        len;
   logic [LEN_W-1:0]        len_eff;
   logic                    accept;
   logic                    first;
   logic                    last;

   logic signed [SUM_W-1:0] sum_q   [NUM_CH];
   logic signed [SUM_W-1:0] bias_q  [NUM_CH];
   logic signed [SUM_W-1:0] base_v  [NUM_CH];
   logic signed [SUM_W-1:0] ext_v   [NUM_CH];
   logic signed [SUM_W:0]   full_v  [NUM_CH];
   logic signed [SUM_W-1:0] sum_nxt [NUM_CH];
   logic [NUM_CH-1:0]       ovf_add;
   logic [NUM_CH-1:0]       ovf_q;

   // While holding a result, a new beat can only enter if the result leaves
   // in the same cycle; this gives back-to-back stages with no bubble.
   assign bus.in_ready  = (state == HOLD) ? bus.out_ready : 1'b1;
   assign bus.out_valid = (state == HOLD);
   assign bus.overflow  = ovf_q;

   assign accept  = bus.in_valid && bus.in_ready;
   assign first   = accept && (state != ACCUM);
   assign len_eff = (bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len;
   assign last    = first ? (len_eff == LEN_W'(1))
                          : (accept && ((cnt + LEN_W'(1)) == len));

   // State register
   always_ff @(posedge clk or posedge layer_reset) begin
      if (layer_reset) state <= IDLE;
      else             state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, HOLD: begin
            if (accept)                 state_nxt = last ? HOLD : ACCUM;
            else if (state == HOLD && bus.out_ready) state_nxt = IDLE;
         end
         ACCUM: begin
            if (last) state_nxt = HOLD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Per-lane add at SUM_W+1 bits with overflow detect and optional clamp
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ext_v[i]   = SUM_W'(signed'(bus.addend[i*ADDEND_W +: ADDEND_W]));
         base_v[i]  = first ? bias_q[i] : sum_q[i];
         full_v[i]  = (SUM_W+1)'(base_v[i]) + (SUM_W+1)'(ext_v[i]);
         ovf_add[i] = full_v[i][SUM_W] ^ full_v[i][SUM_W-1];
         if (SAT_EN && ovf_add[i])
            sum_nxt[i] = full_v[i][SUM_W] ? SUM_MIN : SUM_MAX;
         else
            sum_nxt[i] = full_v[i][SUM_W-1:0];
      end
   end

   // Beat counter and stage length, latched on the first beat
   always_ff @(posedge clk or posedge layer_reset) begin
      if (layer_reset) begin
         cnt <= '0;
         len <= LEN_W'(1);
      end else if (first) begin
         cnt <= LEN_W'(1);
         len <= len_eff;
      end else if (accept) begin
         cnt <= cnt + LEN_W'(1);
      end
   end

   // Accumulators and sticky overflow; a first beat restarts both
   always_ff @(posedge clk or posedge layer_reset) begin
      if (layer_reset) begin
         for (int i = 0; i < NUM_CH; i++) sum_q[i] <= '0;
         ovf_q <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_CH; i++) begin
            sum_q[i] <= sum_nxt[i];
            ovf_q[i] <= first ? ovf_add[i] : (ovf_q[i] | ovf_add[i]);
         end
      end
   end

   // Bias registers; a same-cycle first beat still sees the old value
   always_ff @(posedge clk or posedge layer_reset) begin
      if (layer_reset) begin
         for (int i = 0; i < NUM_CH; i++) bias_q[i] <= '0;
      end else if (bus.bias_load) begin
         for (int i = 0; i < NUM_CH; i++) bias_q[i] <= bus.bias_in[i*SUM_W +: SUM_W];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign bus.sum_out[g*SUM_W +: SUM_W] = sum_q[g];
   end

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank. A saturating and a wrapping instance see
// identical stimulus; expected values are hand-computed constants.
module tb_accum_bank;

   logic clk;
   logic layer_reset;
   int   n_cmp;
   int   n_err;

   accum_bank_if bs ();
   accum_bank_if bw ();

   assign bw.acc_len   = bs.acc_len;
   assign bw.bias_load = bs.bias_load;
   assign bw.bias_in   = bs.bias_in;
   assign bw.in_valid  = bs.in_valid;
   assign bw.addend    = bs.addend;
   assign bw.out_ready = bs.out_ready;

   accum_bank #(.SAT_EN(1'b1)) u_sat  (.clk(clk), .layer_reset(layer_reset), .bus(bs));
   accum_bank #(.SAT_EN(1'b0)) u_wrap (.clk(clk), .layer_reset(layer_reset), .bus(bw));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addend(input int v);
      for (int i = 0; i < 4; i++) bs.addend[i*20 +: 20] = 20'(v);
   endtask

   task automatic load_bias(input int b0, input int b1, input int b2, input int b3);
      bs.bias_in[0 +: 24]  = 24'(b0);
      bs.bias_in[24 +: 24] = 24'(b1);
      bs.bias_in[48 +: 24] = 24'(b2);
      bs.bias_in[72 +: 24] = 24'(b3);
      bs.bias_load = 1'b1;
      step();
      bs.bias_load = 1'b0;
   endtask

   task automatic test_reset();
      layer_reset = 1'b1;
      step();
      step();
      n_cmp++;
      if (bs.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bs.out_valid); end
      n_cmp++;
      if (bs.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bs.in_ready); end
      n_cmp++;
      if (bs.sum_out !== 96'h0) begin n_err++; $display("FAIL reset_sum got %h want 0", bs.sum_out); end
      n_cmp++;
      if (bs.overflow !== 4'h0) begin n_err++; $display("FAIL reset_overflow got %h want 0", bs.overflow); end
      layer_reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int adds[3] = '{5, -2, 10};
      bs.acc_len = 8'd3;
      bs.in_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
         set_addend(adds[b]);
         step();
         n_cmp++;
         if (bs.out_valid !== (b == 2)) begin
            n_err++; $display("FAIL basic_out_valid beat%0d got %b want %b", b, bs.out_valid, (b == 2));
         end
      end
      bs.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bs.sum_out[i*24 +: 24] !== 24'd13) begin
            n_err++; $display("FAIL basic_sum lane%0d got %h want %h", i, bs.sum_out[i*24 +: 24], 24'd13);
         end
      end
      n_cmp++;
      if (bs.overflow !== 4'h0) begin n_err++; $display("FAIL basic_overflow got %h want 0", bs.overflow); end
      step();
      n_cmp++;
      if (bs.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b want 0", bs.out_valid); end
   endtask

   task automatic test_bias();
      logic [23:0] exp [4];
      exp[0] = 24'd101; exp[1] = 24'(-99); exp[2] = 24'd1; exp[3] = 24'd8;
      load_bias(100, -100, 0, 7);
      bs.acc_len = 8'd1;
      set_addend(1);
      bs.in_valid = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bs.sum_out[i*24 +: 24] !== exp[i]) begin
            n_err++; $display("FAIL bias_sum lane%0d got %h want %h", i, bs.sum_out[i*24 +: 24], exp[i]);
         end
      end
      bs.bias_in = '0;
      bs.bias_load = 1'b1;
      step();
      bs.bias_load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bs.sum_out[i*24 +: 24] !== exp[i]) begin
            n_err++; $display("FAIL bias_old_used lane%0d got %h want %h", i, bs.sum_out[i*24 +: 24], exp[i]);
         end
      end
      step();
      n_cmp++;
      if (bs.sum_out !== {4{24'd1}}) begin n_err++; $display("FAIL bias_new_applied got %h want %h", bs.sum_out, {4{24'd1}}); end
      bs.in_valid = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      load_bias(24'h7FFFF0, 24'h7FFFF0, 24'h7FFFF0, 24'h7FFFF0);
      bs.acc_len = 8'd1;
      set_addend(32'h20);
      bs.in_valid = 1'b1;
      step();
      bs.in_valid = 1'b0;
      n_cmp++;
      if (bs.sum_out !== {4{24'h7FFFFF}}) begin n_err++; $display("FAIL sat_pos_sum got %h want %h", bs.sum_out, {4{24'h7FFFFF}}); end
      n_cmp++;
      if (bs.overflow !== 4'hF) begin n_err++; $display("FAIL sat_pos_ovf got %h want F", bs.overflow); end
      n_cmp++;
      if (bw.sum_out !== {4{24'h800010}}) begin n_err++; $display("FAIL wrap_pos_sum got %h want %h", bw.sum_out, {4{24'h800010}}); end
      n_cmp++;
      if (bw.overflow !== 4'hF) begin n_err++; $display("FAIL wrap_pos_ovf got %h want F", bw.overflow); end
      load_bias(24'h800000, 24'h800000, 24'h800000, 24'h800000);
      set_addend(-1);
      bs.in_valid = 1'b1;
      step();
      bs.in_valid = 1'b0;
      n_cmp++;
      if (bs.sum_out !== {4{24'h800000}}) begin n_err++; $display("FAIL sat_neg_sum got %h want %h", bs.sum_out, {4{24'h800000}}); end
      n_cmp++;
      if (bw.sum_out !== {4{24'h7FFFFF}}) begin n_err++; $display("FAIL wrap_neg_sum got %h want %h", bw.sum_out, {4{24'h7FFFFF}}); end
      n_cmp++;
      if ({bs.overflow, bw.overflow} !== 8'hFF) begin n_err++; $display("FAIL neg_ovf got %h want FF", {bs.overflow, bw.overflow}); end
      load_bias(24'h7FFFF0, 24'h7FFFF0, 24'h7FFFF0, 24'h7FFFF0);
      bs.acc_len = 8'd2;
      set_addend(32'h20);
      bs.in_valid = 1'b1;
      step();
      n_cmp++;
      if ({bs.out_valid, bs.overflow} !== 5'h0F) begin n_err++; $display("FAIL mid_stage_ovf got %h want 0F", {bs.out_valid, bs.overflow}); end
      set_addend(-256);
      step();
      bs.in_valid = 1'b0;
      n_cmp++;
      if (bs.sum_out !== {4{24'h7FFEFF}}) begin n_err++; $display("FAIL sat_sticky_sum got %h want %h", bs.sum_out, {4{24'h7FFEFF}}); end
      n_cmp++;
      if (bw.sum_out !== {4{24'h7FFF10}}) begin n_err++; $display("FAIL wrap_sticky_sum got %h want %h", bw.sum_out, {4{24'h7FFF10}}); end
      n_cmp++;
      if (bs.overflow !== 4'hF) begin n_err++; $display("FAIL sticky_ovf got %h want F", bs.overflow); end
      load_bias(0, 0, 0, 0);
      bs.acc_len = 8'd1;
      set_addend(3);
      bs.in_valid = 1'b1;
      step();
      bs.in_valid = 1'b0;
      n_cmp++;
      if ({bs.overflow, bw.overflow} !== 8'h00) begin n_err++; $display("FAIL ovf_cleared got %h want 00", {bs.overflow, bw.overflow}); end
      n_cmp++;
      if (bs.sum_out !== {4{24'd3}}) begin n_err++; $display("FAIL clear_sum got %h want %h", bs.sum_out, {4{24'd3}}); end
      step();
   endtask

   task automatic test_hold();
      load_bias(50, 50, 50, 50);
      bs.out_ready = 1'b0;
      bs.acc_len = 8'd1;
      set_addend(7);
      bs.in_valid = 1'b1;
      step();
      set_addend(9);
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if ({bs.in_ready, bs.out_valid} !== 2'b01) begin
            n_err++; $display("FAIL hold_handshake cyc%0d got %b want 01", c, {bs.in_ready, bs.out_valid});
         end
         n_cmp++;
         if (bs.sum_out !== {4{24'd57}}) begin
            n_err++; $display("FAIL hold_sum cyc%0d got %h want %h", c, bs.sum_out, {4{24'd57}});
         end
         step();
      end
      bs.out_ready = 1'b1;
      set_addend(4);
      #1;
      n_cmp++;
      if (bs.in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got %b want 1", bs.in_ready); end
      step();
      bs.in_valid = 1'b0;
      n_cmp++;
      if ({bs.out_valid, bs.sum_out} !== {1'b1, {4{24'd54}}}) begin
         n_err++; $display("FAIL back_to_back got %b %h want 1 %h", bs.out_valid, bs.sum_out, {4{24'd54}});
      end
      step();
   endtask

   task automatic test_len();
      bs.acc_len = 8'd0;
      bs.in_valid = 1'b1;
      for (int b = 1; b <= 3; b++) begin
         set_addend(b);
         step();
         n_cmp++;
         if ({bs.out_valid, bs.sum_out[23:0]} !== {1'b1, 24'(50 + b)}) begin
            n_err++; $display("FAIL len0_beat%0d got %b %h want 1 %h", b, bs.out_valid, bs.sum_out[23:0], 24'(50 + b));
         end
      end
      bs.acc_len = 8'd4;
      set_addend(1);
      step();
      bs.acc_len = 8'd2;
      for (int b = 2; b <= 4; b++) begin
         n_cmp++;
         if (bs.out_valid !== 1'b0) begin n_err++; $display("FAIL len_latch_early before_beat%0d got %b want 0", b, bs.out_valid); end
         step();
      end
      bs.in_valid = 1'b0;
      n_cmp++;
      if ({bs.out_valid, bs.sum_out} !== {1'b1, {4{24'd54}}}) begin
         n_err++; $display("FAIL len_latch_done got %b %h want 1 %h", bs.out_valid, bs.sum_out, {4{24'd54}});
      end
      step();
   endtask

   task automatic test_reset_mid();
      bs.acc_len = 8'd4;
      set_addend(10);
      bs.in_valid = 1'b1;
      step();
      step();
      bs.in_valid = 1'b0;
      #2;
      layer_reset = 1'b1;
      #1;
      n_cmp++;
      if ({bs.out_valid, bs.overflow, bs.sum_out} !== 101'h0) begin
         n_err++; $display("FAIL reset_mid got %b %h %h want 0", bs.out_valid, bs.overflow, bs.sum_out);
      end
      step();
      layer_reset = 1'b0;
      bs.in_valid = 1'b1;
      for (int b = 1; b <= 4; b++) begin
         set_addend(b);
         step();
      end
      bs.in_valid = 1'b0;
      n_cmp++;
      if ({bs.out_valid, bs.sum_out} !== {1'b1, {4{24'd10}}}) begin
         n_err++; $display("FAIL after_reset_sum got %b %h want 1 %h", bs.out_valid, bs.sum_out, {4{24'd10}});
      end
      bs.out_ready = 1'b0;
      step();
      #2;
      layer_reset = 1'b1;
      #1;
      n_cmp++;
      if ({bs.out_valid, bs.sum_out} !== 97'h0) begin
         n_err++; $display("FAIL reset_in_hold got %b %h want 0", bs.out_valid, bs.sum_out);
      end
      step();
      layer_reset = 1'b0;
      bs.out_ready = 1'b1;
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      layer_reset = 1'b1;
      bs.acc_len = 8'd1;
      bs.bias_load = 1'b0;
      bs.bias_in = '0;
      bs.in_valid = 1'b0;
      bs.addend = '0;
      bs.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_bias();
      test_overflow();
      test_hold();
      test_len();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accum_bank.md
Name: accum_bank

Overview:
- Multi-lane partial-sum accumulator for the convolution datapath.
- Sums a programmable number of signed addends per output pixel (one stage) for NUM_CH output channels in parallel.
- Adds a per-lane bias preload and optional saturation.
- Presents each completed sum on a valid/ready output handshake so the downstream activation/pooling unit can stall it.

Parameters:
- NUM_CH, 4, number of parallel accumulator lanes.
- ADDEND_W, 20, signed addend width per lane.
- SUM_W, 24, signed accumulator/result width per lane; must be >= ADDEND_W.
- LEN_W, 8, width of the stage-length field.
- SAT_EN, 1, 1 = clamp to signed SUM_W range on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- layer_reset  in  1  reset, asynchronous, active-high.
- acc_len  in  LEN_W  addends per stage; sampled on the first beat of a stage; value 0 is treated as 1.
- bias_load  in  1  loads bias_in into the lane bias registers.
- bias_in  in  NUM_CH*SUM_W  per-lane signed bias; lane i is at [i*SUM_W +: SUM_W].
- in_valid  in  1  addend beat valid.
- in_ready  out  1  block can accept a beat.
- addend  in  NUM_CH*ADDEND_W  per-lane signed addends; lane i is at [i*ADDEND_W +: ADDEND_W].
- out_valid  out  1  sum_out holds a completed stage.
- out_ready  in  1  downstream accepts sum_out.
- sum_out  out  NUM_CH*SUM_W  per-lane accumulated result (the accumulator registers).
- overflow  out  NUM_CH  per-lane sticky overflow flag for the current/completed stage.

Behaviour:
- Reset (async on layer_reset high):
  - state = IDLE, beat counter = 0, latched length = 1.
  - All sums = 0, all bias registers = 0, overflow = 0, out_valid = 0.
- Beat accept: a beat is accepted on any clk edge where in_valid && in_ready.
- States: IDLE, ACCUM, HOLD.
  - IDLE: in_ready = 1, out_valid = 0.
    - Accepted beat is the first beat: sum = bias + sext(addend); overflow cleared and then re-evaluated for this add; len = max(acc_len, 1); cnt = 1.
    - If len == 1, go to HOLD; else go to ACCUM.
  - ACCUM: in_ready = 1, out_valid = 0.
    - Accepted beat: sum = sum + sext(addend); cnt++.
    - When the post-increment cnt == len, go to HOLD.
    - No beat: hold all state.
  - HOLD: out_valid = 1; sum_out and overflow are stable; in_ready = out_ready.
    - out_ready = 0: stay in HOLD; no input accepted.
    - out_ready = 1 and no beat: go to IDLE.
    - out_ready = 1 and a beat is accepted in the same cycle: that beat is the first beat of the next stage (IDLE first-beat rules) with zero bubble.
- Output latency: out_valid asserts the cycle after the last beat is accepted.
- Arithmetic (per lane, independent):
  - Each addend is sign-extended to SUM_W.
  - The sum is computed at SUM_W+1 bits; overflow occurs when the two MSBs of the SUM_W+1 result differ.
  - SAT_EN = 1: result clamps to 2^(SUM_W-1)-1 or -2^(SUM_W-1) according to the overflow direction.
  - SAT_EN = 0: result keeps the low SUM_W bits (wrap).
  - In both modes, overflow[i] is set and stays set until the next first beat.
- Bias:
  - bias_load updates the bias registers in any state.
  - A first beat in the same cycle as bias_load uses the old (registered) bias; the new bias applies from the next stage.
- acc_len: changes mid-stage have no effect; only the value latched on the first beat is used.
- Reset mid-stage: the partial sum is discarded, the bias returns to 0, and any pending out_valid drops immediately (asynchronously).

Test Plan:
- NUM_CH=4, bias 0, acc_len=3; addends per lane {5,-2,10} -> out_valid one cycle after the 3rd beat; every lane sum_out = 13; overflow = 0.
- bias_load with lane biases {100,-100,0,7}, then acc_len=1, addend 1 on all lanes -> sum_out = {101,-99,1,8}.
- SUM_W=24, SAT_EN=1; bias 0x7FFFF0 plus addend +0x20 -> sum_out = 0x7FFFFF, overflow = 1. Repeat with SAT_EN=0 -> sum_out = 0x800010, overflow = 1.
- Hold out_ready=0 for 5 cycles after a completed stage -> in_ready = 0, sum_out unchanged, out_valid = 1. Then raise out_ready with in_valid=1 and addend 4 -> next stage starts that cycle; the following sum = bias + 4.
- acc_len=0 -> every beat completes a stage (behaves as length 1). Change acc_len from 4 to 2 after the 1st beat -> the stage still completes after 4 beats.
- Assert layer_reset while in ACCUM after 2 of 4 beats -> out_valid, sum_out, overflow and bias all read 0 immediately. After release, a fresh stage of 4 beats gives the correct sum.
